// File: rtl/usb_bulk_in_arbiter_if.sv
// Stream bundle between NUM_SRC byte-wide producers, the bulk IN arbiter and the bulk IN port.
// The master modport is the arbiter's view; slave is the surrounding producers/endpoint.
interface usb_bulk_in_arbiter_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC-1:0]   s_axis_tvalid_i;
    logic [NUM_SRC-1:0]   s_axis_tready_o;
    logic [NUM_SRC-1:0]   s_axis_tlast_i;
    logic [8*NUM_SRC-1:0] s_axis_tdata_i;
    logic                 m_axis_tvalid_o;
    logic                 m_axis_tready_i;
    logic                 m_axis_tlast_o;
    logic [7:0]           m_axis_tdata_o;

    modport master (
        input  s_axis_tvalid_i, s_axis_tlast_i, s_axis_tdata_i, m_axis_tready_i,
        output s_axis_tready_o, m_axis_tvalid_o, m_axis_tlast_o, m_axis_tdata_o
    );

    modport slave (
        output s_axis_tvalid_i, s_axis_tlast_i, s_axis_tdata_i, m_axis_tready_i,
        input  s_axis_tready_o, m_axis_tvalid_o, m_axis_tlast_o, m_axis_tdata_o
    );
endinterface

// File: rtl/usb_bulk_in_arbiter.sv
// Packet-granular round-robin arbiter sharing one bulk IN stream between NUM_SRC producers,
// with an optional source-index header byte and a per-packet length cap.
module usb_bulk_in_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int MAX_PKT_LEN = 512,
    parameter int ADD_HEADER  = 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    usb_bulk_in_arbiter_if.master bus,
    output logic [NUM_SRC-1:0]    grant_o,
    output logic                  busy_o
);
    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t             state_q;
    logic [NUM_SRC-1:0] grant_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               busy_q;

    logic [7:0]         src_byte [NUM_SRC];
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;
    logic               cap_hit;
    logic               beat_done;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_byte[i] = bus.s_axis_tdata_i[8*i +: 8];
        end
    end

    // Search starts just after the last served source, so it ends up with lowest priority.
    // NOTE: every always_comb output gets a default up front so no path can infer a latch.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_SRC);
            if (!win_found && bus.s_axis_tvalid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // The cap counts the header too, so the forced tlast lands on byte MAX_PKT_LEN.
    assign cap_hit = (count_q == CNT_W'(MAX_PKT_LEN - 1));

    // Stream path is combinational so DATA adds no latency between a source and the bulk port.
    always_comb begin
        bus.m_axis_tvalid_o = 1'b0;
        bus.m_axis_tlast_o  = 1'b0;
        bus.m_axis_tdata_o  = 8'h00;
        bus.s_axis_tready_o = '0;
        unique case (state_q)
            HEAD: begin
                bus.m_axis_tvalid_o = 1'b1;
                bus.m_axis_tdata_o  = 8'(ptr_q);
            end
            DATA: begin
                bus.m_axis_tvalid_o        = bus.s_axis_tvalid_i[ptr_q];
                bus.m_axis_tdata_o         = src_byte[ptr_q];
                bus.m_axis_tlast_o         = bus.s_axis_tlast_i[ptr_q] | cap_hit;
                bus.s_axis_tready_o[ptr_q] = bus.m_axis_tready_i;
            end
            default: ;
        endcase
    end

    assign beat_done = bus.m_axis_tvalid_o & bus.m_axis_tready_i;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= IDX_W'(NUM_SRC - 1);
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (win_found) begin
                        grant_q <= NUM_SRC'(1) << win_idx;
                        ptr_q   <= win_idx;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= (ADD_HEADER != 0) ? HEAD : DATA;
                    end
                end
                HEAD: begin
                    if (bus.m_axis_tready_i) begin
                        count_q <= CNT_W'(1);
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (beat_done) begin
                        count_q <= count_q + CNT_W'(1);
                        if (bus.m_axis_tlast_o) begin
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_usb_bulk_in_arbiter.sv
// Self-checking bench: two arbiters (header on / header off, 8-byte cap) against a
// packet-level reference model, plus directed literal expectations.
module tb_usb_bulk_in_arbiter;
    localparam int NS   = 4;
    localparam int MAXP = 8;

    typedef struct packed {
        logic       l;
        logic [7:0] b;
    } beat_t;

    logic clk = 1'b0;
    logic aresetn = 1'b1;
    always #5 clk = ~clk;

    // Index 0: ADD_HEADER=1 instance, index 1: ADD_HEADER=0 instance.
    logic [NS-1:0]   sv [2];
    logic [NS-1:0]   sl [2];
    logic [8*NS-1:0] sd [2];
    logic            mr [2];
    logic [NS-1:0]   a_sr [2];
    logic [NS-1:0]   a_g [2];
    logic            a_mv [2];
    logic            a_ml [2];
    logic [7:0]      a_md [2];
    logic            a_b [2];

    usb_bulk_in_arbiter_if #(.NUM_SRC(NS)) bus_h ();
    usb_bulk_in_arbiter_if #(.NUM_SRC(NS)) bus_n ();

    usb_bulk_in_arbiter #(.NUM_SRC(NS), .MAX_PKT_LEN(MAXP), .ADD_HEADER(1)) dut_h (
        .aclk(clk), .aresetn(aresetn), .bus(bus_h), .grant_o(a_g[0]), .busy_o(a_b[0]));
    usb_bulk_in_arbiter #(.NUM_SRC(NS), .MAX_PKT_LEN(MAXP), .ADD_HEADER(0)) dut_n (
        .aclk(clk), .aresetn(aresetn), .bus(bus_n), .grant_o(a_g[1]), .busy_o(a_b[1]));

    assign bus_h.s_axis_tvalid_i = sv[0];
    assign bus_h.s_axis_tlast_i  = sl[0];
    assign bus_h.s_axis_tdata_i  = sd[0];
    assign bus_h.m_axis_tready_i = mr[0];
    assign a_sr[0] = bus_h.s_axis_tready_o;
    assign a_mv[0] = bus_h.m_axis_tvalid_o;
    assign a_ml[0] = bus_h.m_axis_tlast_o;
    assign a_md[0] = bus_h.m_axis_tdata_o;

    assign bus_n.s_axis_tvalid_i = sv[1];
    assign bus_n.s_axis_tlast_i  = sl[1];
    assign bus_n.s_axis_tdata_i  = sd[1];
    assign bus_n.m_axis_tready_i = mr[1];
    assign a_sr[1] = bus_n.s_axis_tready_o;
    assign a_mv[1] = bus_n.m_axis_tvalid_o;
    assign a_ml[1] = bus_n.m_axis_tlast_o;
    assign a_md[1] = bus_n.m_axis_tdata_o;

    beat_t      src_q [2*NS][$];
    beat_t      cap_q [2][$];
    logic [7:0] sent [NS][$];
    logic [7:0] rx [NS][$];
    logic       vt [$];
    bit         trace_on = 1'b0;

    // Reference model: granted source (-1 = none), header still owed, bytes sent this packet.
    int mg [2]   = '{-1, -1};
    int mptr [2] = '{NS-1, NS-1};
    int mn [2]   = '{0, 0};
    bit mhp [2]  = '{1'b0, 1'b0};

    int bubble_pct = 0;
    int ready_pct  = 100;
    int n_checks   = 0;
    int n_fail     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit queues_empty(input int d);
        for (int i = 0; i < NS; i++) if (src_q[d*NS+i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push(input int d, input int s, input logic [7:0] b, input logic l);
        src_q[d*NS+s].push_back({l, b});
    endtask

    task automatic model_step(input int d);
        bit ev, el, eb;
        logic [7:0] ed;
        logic [NS-1:0] er, eg;
        int g;
        g = mg[d];
        ev = 1'b0; el = 1'b0; eb = 1'b0; ed = 8'h00; er = '0; eg = '0;
        if (aresetn && g >= 0) begin
            eb = 1'b1;
            eg[g] = 1'b1;
            if (mhp[d]) begin
                ev = 1'b1;
                ed = 8'(g);
            end else begin
                ev = sv[d][g];
                ed = sd[d][8*g +: 8];
                el = sl[d][g] || (mn[d] + 1 == MAXP);
                er[g] = mr[d];
            end
        end
        check($sformatf("d%0d tvalid", d), 32'(a_mv[d]), 32'(ev));
        check($sformatf("d%0d s_tready", d), 32'(a_sr[d]), 32'(er));
        check($sformatf("d%0d grant", d), 32'(a_g[d]), 32'(eg));
        check($sformatf("d%0d busy", d), 32'(a_b[d]), 32'(eb));
        if (ev || !aresetn) begin
            check($sformatf("d%0d tdata", d), 32'(a_md[d]), 32'(ed));
            check($sformatf("d%0d tlast", d), 32'(a_ml[d]), 32'(el));
        end
        if (aresetn && a_mv[d] && mr[d]) cap_q[d].push_back({a_ml[d], a_md[d]});
        if (d == 1 && trace_on) vt.push_back(a_mv[1]);

        if (!aresetn) begin
            mg[d] = -1; mptr[d] = NS - 1; mn[d] = 0; mhp[d] = 1'b0;
        end else if (g < 0) begin
            bit found = 1'b0;
            for (int k = 1; k <= NS; k++) begin
                int c = (mptr[d] + k) % NS;
                if (!found && sv[d][c]) begin
                    found = 1'b1; mg[d] = c; mptr[d] = c; mn[d] = 0; mhp[d] = (d == 0);
                end
            end
        end else if (mhp[d]) begin
            if (mr[d]) begin mhp[d] = 1'b0; mn[d] = 1; end
        end else if (ev && mr[d]) begin
            void'(src_q[d*NS+g].pop_front());
            mn[d]++;
            if (el) mg[d] = -1;
        end
    endtask

    // Producers and bulk port change at the falling edge; outputs are compared 1 ns later.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NS; i++) begin
                if (src_q[d*NS+i].size() > 0 && int'($urandom_range(99)) >= bubble_pct) begin
                    sv[d][i] = 1'b1;
                    sd[d][8*i +: 8] = src_q[d*NS+i][0].b;
                    sl[d][i] = src_q[d*NS+i][0].l;
                end else begin
                    sv[d][i] = 1'b0;
                    sd[d][8*i +: 8] = 8'h00;
                    sl[d][i] = 1'b0;
                end
            end
            mr[d] = (int'($urandom_range(99)) < ready_pct);
        end
        #1;
        for (int d = 0; d < 2; d++) model_step(d);
    end

    task automatic wait_done(input int d, input string name);
        int t = 0;
        while (!(queues_empty(d) && mg[d] < 0) && t < 3000) begin
            @(posedge clk); #2;
            t++;
        end
        check({name, " done"}, 32'(t < 3000), 32'd1);
    endtask

    task automatic check_beat(input int d, input int idx, input logic [7:0] b, input logic l,
                              input string name);
        if (idx >= cap_q[d].size()) check({name, " present"}, 32'(cap_q[d].size()), 32'(idx + 1));
        else check(name, 32'(cap_q[d][idx]), 32'({l, b}));
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        aresetn = 1'b0;
        @(posedge clk); #2;
        aresetn = 1'b1;
    endtask

    initial begin
        int st;
        logic exp_vt [8];
        for (int d = 0; d < 2; d++) begin
            sv[d] = '0; sl[d] = '0; sd[d] = '0; mr[d] = 1'b0;
        end
        #1 aresetn = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset tvalid", 32'(a_mv[0]), 32'd0);
        check("reset grant", 32'(a_g[0]), 32'd0);
        check("reset busy", 32'(a_b[1]), 32'd0);
        aresetn = 1'b1;

        // Single source, 3-byte message.
        @(posedge clk); #2;
        st = cap_q[0].size();
        push(0, 0, 8'hAA, 1'b0); push(0, 0, 8'hBB, 1'b0); push(0, 0, 8'hCC, 1'b1);
        @(posedge clk); #2;
        check("t1 grant src0", 32'(a_g[0]), 32'b0001);
        wait_done(0, "t1");
        check("t1 grant cleared", 32'(a_g[0]), 32'd0);
        check_beat(0, st,     8'h00, 1'b0, "t1 hdr");
        check_beat(0, st + 1, 8'hAA, 1'b0, "t1 b0");
        check_beat(0, st + 2, 8'hBB, 1'b0, "t1 b1");
        check_beat(0, st + 3, 8'hCC, 1'b1, "t1 b2");

        // All four sources requesting, two rounds of 1-byte messages, from reset priority.
        pulse_reset();
        st = cap_q[0].size();
        for (int i = 0; i < NS; i++) begin
            push(0, i, 8'(8'h10 + i), 1'b1);
            push(0, i, 8'(8'h20 + i), 1'b1);
        end
        wait_done(0, "t2");
        for (int p = 0; p < 8; p++) begin
            check_beat(0, st + 2*p, 8'(p % NS), 1'b0, $sformatf("t2 hdr%0d", p));
            check_beat(0, st + 2*p + 1, 8'(((p < NS) ? 8'h10 : 8'h20) + (p % NS)), 1'b1,
                       $sformatf("t2 data%0d", p));
        end

        // Length cap splits a 10-byte message from source 2.
        st = cap_q[0].size();
        for (int i = 0; i < 10; i++) push(0, 2, 8'(i), (i == 9));
        wait_done(0, "t3");
        check_beat(0, st, 8'h02, 1'b0, "t3 hdr a");
        for (int k = 0; k < 7; k++) check_beat(0, st + 1 + k, 8'(k), (k == 6), $sformatf("t3 a%0d", k));
        check_beat(0, st + 8, 8'h02, 1'b0, "t3 hdr b");
        for (int k = 0; k < 3; k++) check_beat(0, st + 9 + k, 8'(7 + k), (k == 2), $sformatf("t3 b%0d", k));

        // Random backpressure and source bubbles; reassemble per-source streams by header.
        st = cap_q[0].size();
        bubble_pct = 30;
        ready_pct  = 50;
        for (int i = 0; i < NS; i++) begin
            for (int m = 0; m < 4; m++) begin
                int len = int'($urandom_range(12, 1));
                for (int j = 0; j < len; j++) begin
                    logic [7:0] b = 8'($urandom_range(255));
                    push(0, i, b, (j == len - 1));
                    sent[i].push_back(b);
                end
            end
        end
        wait_done(0, "t4");
        bubble_pct = 0;
        ready_pct  = 100;
        begin
            int cur = -1;
            bit want_hdr = 1'b1;
            for (int k = st; k < cap_q[0].size(); k++) begin
                if (want_hdr) begin
                    cur = int'(cap_q[0][k].b);
                    want_hdr = 1'b0;
                end else begin
                    if (cur >= 0 && cur < NS) rx[cur].push_back(cap_q[0][k].b);
                    if (cap_q[0][k].l) want_hdr = 1'b1;
                end
            end
            for (int i = 0; i < NS; i++) begin
                bit same = (rx[i].size() == sent[i].size());
                check($sformatf("t4 src%0d length", i), 32'(rx[i].size()), 32'(sent[i].size()));
                if (same) for (int j = 0; j < sent[i].size(); j++) if (rx[i][j] !== sent[i][j]) same = 1'b0;
                check($sformatf("t4 src%0d bytes", i), 32'(same), 32'd1);
            end
        end

        // Reset in the middle of a packet, after header plus five data bytes.
        st = cap_q[0].size();
        for (int i = 0; i < 10; i++) push(0, 0, 8'(8'h40 + i), (i == 9));
        begin
            int t = 0;
            while (cap_q[0].size() < st + 6 && t < 200) begin
                @(posedge clk); #2;
                t++;
            end
            check("t5 reached 5 bytes", 32'(t < 200), 32'd1);
        end
        check("t5 busy before reset", 32'(a_b[0]), 32'd1);
        aresetn = 1'b0;
        #1;
        check("t5 rst tvalid", 32'(a_mv[0]), 32'd0);
        check("t5 rst tlast", 32'(a_ml[0]), 32'd0);
        check("t5 rst tdata", 32'(a_md[0]), 32'd0);
        check("t5 rst tready", 32'(a_sr[0]), 32'd0);
        check("t5 rst grant", 32'(a_g[0]), 32'd0);
        check("t5 rst busy", 32'(a_b[0]), 32'd0);
        for (int i = 0; i < 2*NS; i++) src_q[i].delete();
        st = cap_q[0].size();
        push(0, 2, 8'h77, 1'b1);
        push(0, 0, 8'h55, 1'b1);
        @(posedge clk); #2;
        aresetn = 1'b1;
        @(posedge clk); #2;
        check("t5 src0 wins after reset", 32'(a_g[0]), 32'b0001);
        wait_done(0, "t5");
        check_beat(0, st,     8'h00, 1'b0, "t5 hdr0");
        check_beat(0, st + 1, 8'h55, 1'b1, "t5 d0");
        check_beat(0, st + 2, 8'h02, 1'b0, "t5 hdr2");
        check_beat(0, st + 3, 8'h77, 1'b1, "t5 d2");

        // No header: sources 1 and 3, one idle cycle between packets.
        @(posedge clk); #2;
        st = cap_q[1].size();
        push(1, 1, 8'h31, 1'b0); push(1, 1, 8'h32, 1'b0); push(1, 1, 8'h33, 1'b1);
        push(1, 3, 8'h71, 1'b0); push(1, 3, 8'h72, 1'b1);
        trace_on = 1'b1;
        wait_done(1, "t6");
        @(posedge clk); #2;
        trace_on = 1'b0;
        check_beat(1, st,     8'h31, 1'b0, "t6 s1b0");
        check_beat(1, st + 1, 8'h32, 1'b0, "t6 s1b1");
        check_beat(1, st + 2, 8'h33, 1'b1, "t6 s1b2");
        check_beat(1, st + 3, 8'h71, 1'b0, "t6 s3b0");
        check_beat(1, st + 4, 8'h72, 1'b1, "t6 s3b1");
        exp_vt = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        check("t6 trace length", 32'(vt.size() >= 8), 32'd1);
        for (int k = 0; k < 8 && k < vt.size(); k++)
            check($sformatf("t6 tvalid cycle%0d", k), 32'(vt[k]), 32'(exp_vt[k]));

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
